// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the two-to-one sram-like arbiter: FSM states, port owner
// encoding and transfer-size constants.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_arb_pick.sv
// Combinational two-way picker: fixed data priority or round-robin where the
// port not granted last wins a tie.
module arb_pick
  import sram_like_arbiter_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic   inst_req,
  input  logic   data_req,
  input  owner_e last_grant,
  output owner_e grant
);

  always_comb begin
    grant = OWN_INST;
    if (inst_req && data_req) begin
      if (DATA_PRIO) grant = OWN_DATA;
      else           grant = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
    end else if (data_req) begin
      grant = OWN_DATA;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the instruction and data sram-like master ports onto one shared
// port; one transaction in flight, responses routed back to the latched owner.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  owner_e            grant;
  logic              addr_hs;
  logic              data_hs;

  arb_pick #(.DATA_PRIO(DATA_PRIO)) u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // NOTE: every signal written here gets its default first so no path leaves
  // it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (inst_req || data_req) begin
          owner_d      = grant;
          last_grant_d = grant;
          if (grant == OWN_DATA) begin
            wr_d    = data_wr;
            size_d  = data_size;
            addr_d  = data_addr;
            wdata_d = data_wdata;
          end else begin
            wr_d    = inst_wr;
            size_d  = inst_size;
            addr_d  = inst_addr;
            wdata_d = inst_wdata;
          end
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: if (mem_addr_ok) state_d = ST_DATA;
      ST_DATA: if (mem_data_ok) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      last_grant_q <= OWN_INST;
      wr_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Memory-side oks only count in the phase that expects them.
  assign addr_hs = (state_q == ST_ADDR) && mem_addr_ok;
  assign data_hs = (state_q == ST_DATA) && mem_data_ok;

  assign mem_req   = (state_q == ST_ADDR);
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign inst_addr_ok = addr_hs && (owner_q == OWN_INST);
  assign data_addr_ok = addr_hs && (owner_q == OWN_DATA);
  assign inst_data_ok = data_hs && (owner_q == OWN_INST);
  assign data_data_ok = data_hs && (owner_q == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench: instance 0 uses fixed data priority, instance 1 round-robin.
// Expected handshakes are queued at issue time and popped by a negedge monitor.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  typedef struct {
    bit          is_data;
    owner_e      own;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req [2], inst_wr [2], data_req [2], data_wr [2];
  logic [1:0]  inst_size [2], data_size [2], mem_size [2];
  logic [31:0] inst_addr [2], inst_wdata [2], data_addr [2], data_wdata [2];
  logic        inst_addr_ok [2], inst_data_ok [2], data_addr_ok [2], data_data_ok [2];
  logic [31:0] inst_rdata [2], data_rdata [2];
  logic        mem_req [2], mem_wr [2], mem_addr_ok [2], mem_data_ok [2];
  logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];

  ev_t exp_q0[$];
  ev_t exp_q1[$];
  int  n_pass = 0;
  int  n_total = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.DATA_PRIO(1'b1), .ADDR_W(32), .DATA_W(32)) u_dut_prio (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[0]), .inst_wr(inst_wr[0]), .inst_size(inst_size[0]),
    .inst_addr(inst_addr[0]), .inst_wdata(inst_wdata[0]),
    .inst_addr_ok(inst_addr_ok[0]), .inst_data_ok(inst_data_ok[0]), .inst_rdata(inst_rdata[0]),
    .data_req(data_req[0]), .data_wr(data_wr[0]), .data_size(data_size[0]),
    .data_addr(data_addr[0]), .data_wdata(data_wdata[0]),
    .data_addr_ok(data_addr_ok[0]), .data_data_ok(data_data_ok[0]), .data_rdata(data_rdata[0]),
    .mem_req(mem_req[0]), .mem_wr(mem_wr[0]), .mem_size(mem_size[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_addr_ok(mem_addr_ok[0]), .mem_data_ok(mem_data_ok[0]), .mem_rdata(mem_rdata[0])
  );

  sram_like_arbiter #(.DATA_PRIO(1'b0), .ADDR_W(32), .DATA_W(32)) u_dut_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req[1]), .inst_wr(inst_wr[1]), .inst_size(inst_size[1]),
    .inst_addr(inst_addr[1]), .inst_wdata(inst_wdata[1]),
    .inst_addr_ok(inst_addr_ok[1]), .inst_data_ok(inst_data_ok[1]), .inst_rdata(inst_rdata[1]),
    .data_req(data_req[1]), .data_wr(data_wr[1]), .data_size(data_size[1]),
    .data_addr(data_addr[1]), .data_wdata(data_wdata[1]),
    .data_addr_ok(data_addr_ok[1]), .data_data_ok(data_data_ok[1]), .data_rdata(data_rdata[1]),
    .mem_req(mem_req[1]), .mem_wr(mem_wr[1]), .mem_size(mem_size[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_addr_ok(mem_addr_ok[1]), .mem_data_ok(mem_data_ok[1]), .mem_rdata(mem_rdata[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic ev_t qpop(input int i);
    if (i == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic qpush(input int i, input ev_t e);
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Queue the addr_ok and (optionally) data_ok a transaction should produce.
  task automatic expect_txn(input int i, input owner_e own, input logic wr,
                            input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input bit with_data);
    ev_t e;
    e.is_data = 1'b0; e.own = own; e.wr = wr; e.size = size;
    e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    qpush(i, e);
    if (with_data) begin
      e.is_data = 1'b1;
      qpush(i, e);
    end
  endtask

  task automatic mon(input int i);
    logic [1:0] a;
    logic [1:0] d;
    ev_t        e;
    a = {data_addr_ok[i], inst_addr_ok[i]};
    d = {data_data_ok[i], inst_data_ok[i]};
    if (a != 2'b00) begin
      if (qsize(i) == 0) check($sformatf("stray_addr_ok%0d", i), 64'(a), 64'd0);
      else begin
        e = qpop(i);
        check("addr_ok_kind", 64'(e.is_data), 64'd0);
        check("addr_ok_owner", 64'(a), (e.own == OWN_DATA) ? 64'd2 : 64'd1);
        check("addr_mem_req", 64'(mem_req[i]), 64'd1);
        check("addr_mem_wr", 64'(mem_wr[i]), 64'(e.wr));
        check("addr_mem_size", 64'(mem_size[i]), 64'(e.size));
        check("addr_mem_addr", 64'(mem_addr[i]), 64'(e.addr));
        check("addr_mem_wdata", 64'(mem_wdata[i]), 64'(e.wdata));
      end
    end
    if (d != 2'b00) begin
      if (qsize(i) == 0) check($sformatf("stray_data_ok%0d", i), 64'(d), 64'd0);
      else begin
        e = qpop(i);
        check("data_ok_kind", 64'(e.is_data), 64'd1);
        check("data_ok_owner", 64'(d), (e.own == OWN_DATA) ? 64'd2 : 64'd1);
        if (e.own == OWN_DATA) begin
          check("data_rdata", 64'(data_rdata[i]), 64'(e.rdata));
          check("inst_rdata_idle", 64'(inst_rdata[i]), 64'd0);
        end else begin
          check("inst_rdata", 64'(inst_rdata[i]), 64'(e.rdata));
          check("data_rdata_idle", 64'(data_rdata[i]), 64'd0);
        end
      end
    end else begin
      check("rdata_zero", {inst_rdata[i], data_rdata[i]}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Memory-side responder for one transaction on instance i.
  task automatic serve(input int i, input int a_dly, input int d_dly,
                       input logic [31:0] rd, input logic [31:0] exp_addr,
                       input logic [1:0] drop, input bit spur, input bit rst_in_data);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(posedge clk); #1;
      found = mem_req[i];
    end
    if (!found) begin
      check($sformatf("mem_req_timeout%0d", i), 64'd0, 64'd1);
      return;
    end
    check("grant_addr", 64'(mem_addr[i]), 64'(exp_addr));
    for (int k = 0; k < a_dly; k++) begin
      @(posedge clk); #1;
      check("addr_wait_req", 64'(mem_req[i]), 64'd1);
      check("addr_wait_addr", 64'(mem_addr[i]), 64'(exp_addr));
    end
    mem_addr_ok[i] = 1'b1;
    @(posedge clk); #1;
    mem_addr_ok[i] = 1'b0;
    if (drop[0]) inst_req[i] = 1'b0;
    if (drop[1]) data_req[i] = 1'b0;
    check("data_phase_req", 64'(mem_req[i]), 64'd0);
    if (rst_in_data) begin
      mem_data_ok[i] = 1'b1;
      mem_rdata[i]   = rd;
      rst            = 1'b0;
      @(negedge clk);
      check("rst_mem_req", 64'(mem_req[i]), 64'd0);
      check("rst_mem_addr", 64'(mem_addr[i]), 64'd0);
      check("rst_mem_wr_size", {mem_wr[i], mem_size[i]}, 64'd0);
      @(posedge clk); #1;
      rst            = 1'b1;
      mem_data_ok[i] = 1'b0;
      mem_rdata[i]   = '0;
      return;
    end
    for (int j = 0; j < d_dly; j++) begin
      @(posedge clk); #1;
      mem_addr_ok[i] = spur && (j == 0);
      check("data_wait_req", 64'(mem_req[i]), 64'd0);
    end
    mem_addr_ok[i] = 1'b0;
    mem_data_ok[i] = 1'b1;
    mem_rdata[i]   = rd;
    @(posedge clk); #1;
    mem_data_ok[i] = 1'b0;
    mem_rdata[i]   = '0;
  endtask

  task automatic drive_inst(input int i, input logic [31:0] addr);
    inst_req[i] = 1'b1; inst_wr[i] = 1'b0; inst_size[i] = SIZE_WORD;
    inst_addr[i] = addr; inst_wdata[i] = '0;
  endtask

  task automatic drive_data(input int i, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
    data_req[i] = 1'b1; data_wr[i] = wr; data_size[i] = size;
    data_addr[i] = addr; data_wdata[i] = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      inst_req[i] = 0; inst_wr[i] = 0; inst_size[i] = 0; inst_addr[i] = 0; inst_wdata[i] = 0;
      data_req[i] = 0; data_wr[i] = 0; data_size[i] = 0; data_addr[i] = 0; data_wdata[i] = 0;
      mem_addr_ok[i] = 0; mem_data_ok[i] = 0; mem_rdata[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_mem_req", 64'(mem_req[i]), 64'd0);
      check("reset_mem_fields", {mem_wr[i], mem_size[i], mem_addr[i]}, 64'd0);
      check("reset_mem_wdata", 64'(mem_wdata[i]), 64'd0);
      check("reset_oks", {inst_addr_ok[i], inst_data_ok[i], data_addr_ok[i], data_data_ok[i]}, 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Instruction fetch alone: addr_ok in cycle 2, data_ok in cycle 4.
    drive_inst(0, 32'hBFC0_0000);
    expect_txn(0, OWN_INST, 1'b0, SIZE_WORD, 32'hBFC0_0000, 32'h0, 32'h3C1D_0001, 1'b1);
    serve(0, 1, 1, 32'h3C1D_0001, 32'hBFC0_0000, 2'b01, 1'b0, 1'b0);

    // Simultaneous requests with data priority: data write first, then fetch.
    drive_inst(0, 32'hBFC0_0004);
    drive_data(0, 1'b1, SIZE_WORD, 32'h8000_1000, 32'h1234_5678);
    expect_txn(0, OWN_DATA, 1'b1, SIZE_WORD, 32'h8000_1000, 32'h1234_5678, 32'h0, 1'b1);
    expect_txn(0, OWN_INST, 1'b0, SIZE_WORD, 32'hBFC0_0004, 32'h0, 32'h2408_0005, 1'b1);
    serve(0, 0, 0, 32'h0, 32'h8000_1000, 2'b10, 1'b0, 1'b0);
    serve(0, 0, 0, 32'h2408_0005, 32'hBFC0_0004, 2'b01, 1'b0, 1'b0);

    // Slow memory: long ADDR and DATA phases.
    drive_data(0, 1'b0, SIZE_HALF, 32'h8000_2000, 32'h0);
    expect_txn(0, OWN_DATA, 1'b0, SIZE_HALF, 32'h8000_2000, 32'h0, 32'hCAFE_F00D, 1'b1);
    serve(0, 5, 7, 32'hCAFE_F00D, 32'h8000_2000, 2'b10, 1'b0, 1'b0);

    // Spurious oks while idle, then a spurious addr_ok during DATA.
    mem_data_ok[0] = 1'b1; mem_addr_ok[0] = 1'b1; mem_rdata[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_data_ok[0] = 1'b0; mem_addr_ok[0] = 1'b0; mem_rdata[0] = '0;
    check("spurious_idle_req", 64'(mem_req[0]), 64'd0);
    drive_inst(0, 32'hBFC0_0008);
    expect_txn(0, OWN_INST, 1'b0, SIZE_WORD, 32'hBFC0_0008, 32'h0, 32'h0000_000C, 1'b1);
    serve(0, 0, 3, 32'h0000_000C, 32'hBFC0_0008, 2'b01, 1'b1, 1'b0);

    // Reset in the DATA phase drops the in-flight response.
    drive_inst(0, 32'hBFC0_0100);
    expect_txn(0, OWN_INST, 1'b0, SIZE_WORD, 32'hBFC0_0100, 32'h0, 32'h1111_1111, 1'b0);
    serve(0, 0, 0, 32'h1111_1111, 32'hBFC0_0100, 2'b01, 1'b0, 1'b1);
    check("post_rst_req", 64'(mem_req[0]), 64'd0);
    drive_inst(0, 32'hBFC0_0200);
    expect_txn(0, OWN_INST, 1'b0, SIZE_WORD, 32'hBFC0_0200, 32'h0, 32'h8FBF_0010, 1'b1);
    serve(0, 1, 1, 32'h8FBF_0010, 32'hBFC0_0200, 2'b01, 1'b0, 1'b0);

    // Round-robin: a data-only access leaves last_grant=DATA, then both held.
    drive_data(1, 1'b0, SIZE_WORD, 32'h8000_3000, 32'h0);
    expect_txn(1, OWN_DATA, 1'b0, SIZE_WORD, 32'h8000_3000, 32'h0, 32'h0000_0077, 1'b1);
    serve(1, 0, 0, 32'h0000_0077, 32'h8000_3000, 2'b10, 1'b0, 1'b0);
    drive_inst(1, 32'hBFC0_0010);
    drive_data(1, 1'b1, SIZE_WORD, 32'h8000_3004, 32'hA5A5_A5A5);
    expect_txn(1, OWN_INST, 1'b0, SIZE_WORD, 32'hBFC0_0010, 32'h0, 32'h0000_0001, 1'b1);
    expect_txn(1, OWN_DATA, 1'b1, SIZE_WORD, 32'h8000_3004, 32'hA5A5_A5A5, 32'h0, 1'b1);
    expect_txn(1, OWN_INST, 1'b0, SIZE_WORD, 32'hBFC0_0010, 32'h0, 32'h0000_0002, 1'b1);
    expect_txn(1, OWN_DATA, 1'b1, SIZE_WORD, 32'h8000_3004, 32'hA5A5_A5A5, 32'h0, 1'b1);
    serve(1, 0, 0, 32'h0000_0001, 32'hBFC0_0010, 2'b00, 1'b0, 1'b0);
    serve(1, 0, 0, 32'h0,         32'h8000_3004, 2'b00, 1'b0, 1'b0);
    serve(1, 0, 0, 32'h0000_0002, 32'hBFC0_0010, 2'b00, 1'b0, 1'b0);
    serve(1, 0, 0, 32'h0,         32'h8000_3004, 2'b11, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 64'(exp_q0.size()), 64'd0);
    check("q1_drained", 64'(exp_q1.size()), 64'd0);
    check("final_idle", {62'd0, mem_req[1], mem_req[0]}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
